// File: rtl/result_writer_pkg.sv
// Shared types and constants for result_word_writer: FSM states, buffer
// geometry defaults and the word-packing helper.
package result_writer_pkg;

  localparam int DEPTH_DEF = 512;
  localparam int AW_DEF    = 9;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    PAD  = 3'd1,
    RD   = 3'd2,
    REQ  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/word_buffer_m9k.sv
// Simple dual-port word buffer: one write port, one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module word_buffer_m9k #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/result_word_writer.sv
// Packs result bytes low-byte-first into a word buffer and drains it to the
// SDRAM word port on flush. Optional RESULT_WRITER_CHECKSUM_EN adds a drain checksum.
module result_word_writer
  import result_writer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic          flush,
  output logic          sd_req,
  output logic [AW-1:0] sd_address_word,
  output logic [15:0]   sd_data_word,
  input  logic          sd_ack,
  output logic          busy,
  output logic          done,
`ifdef RESULT_WRITER_CHECKSUM_EN
  output logic [15:0]   checksum,
`endif
  output logic [AW:0]   word_count
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        r_state;
  logic [AW:0]   r_word_count;
  logic [AW-1:0] r_drain_ptr;
  logic [7:0]    r_low;
  logic          r_pending;
  logic          r_byte_ready;
  logic          r_sd_req;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_odd;
  logic          w_pend_after;
  logic          w_last;
  logic          w_we;
  logic          w_re;
  logic [AW:0]   w_wc_inc;
  logic [AW:0]   w_wc_after;
  logic [AW-1:0] w_waddr;
  logic [15:0]   w_wdata;
  logic [15:0]   w_rd_data;

  // Byte acceptance, pack bookkeeping and buffer port decode.
  always_comb begin
    w_accept     = (r_state == FILL) && byte_valid && r_byte_ready;
    w_odd        = w_accept && r_pending;
    w_wc_inc     = r_word_count + ONE_W;
    w_wc_after   = w_odd ? w_wc_inc : r_word_count;
    w_pend_after = w_accept ? ~r_pending : r_pending;
    w_last       = (({1'b0, r_drain_ptr} + ONE_W) == r_word_count);
    w_we         = w_odd || (r_state == PAD);
    w_waddr      = r_word_count[AW-1:0];
    w_re         = (r_state == RD);
    if (r_state == PAD) begin
      w_wdata = pack_word(PAD_BYTE, r_low);
    end else begin
      w_wdata = pack_word(byte_data, r_low);
    end
  end

  word_buffer_m9k #(.DEPTH(DEPTH), .AW(AW), .DW(16)) u_buf (
    .clk   (CLOCK_50),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (r_drain_ptr),
    .rdata (w_rd_data)
  );

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state      <= FILL;
      r_word_count <= '0;
      r_drain_ptr  <= '0;
      r_low        <= 8'h00;
      r_pending    <= 1'b0;
      r_byte_ready <= 1'b1;
      r_sd_req     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_pending) begin
              r_pending    <= 1'b0;
              r_word_count <= w_wc_inc;
            end else begin
              r_low     <= byte_data;
              r_pending <= 1'b1;
            end
          end
          if (flush) begin
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b1;
            if (w_pend_after) begin
              r_state <= PAD;
            end else if (w_wc_after != '0) begin
              r_state <= RD;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_byte_ready <= (w_wc_after < DEPTH_W);
          end
        end
        PAD: begin
          r_word_count <= w_wc_inc;
          r_pending    <= 1'b0;
          r_state      <= RD;
        end
        RD: begin
          r_sd_req <= 1'b1;
          r_state  <= REQ;
        end
        REQ: begin
          if (sd_ack) begin
            r_sd_req <= 1'b0;
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_drain_ptr <= r_drain_ptr + 1'b1;
              r_state     <= RD;
            end
          end
        end
        DONE: begin
          r_word_count <= '0;
          r_drain_ptr  <= '0;
          r_pending    <= 1'b0;
          r_byte_ready <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= FILL;
        end
        default: begin
          r_state      <= FILL;
          r_sd_req     <= 1'b0;
          r_byte_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESULT_WRITER_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running sum of acknowledged words; restarts whenever a new drain begins.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_checksum <= 16'h0000;
    end else if ((r_state == PAD) ||
                 ((r_state == FILL) && flush && !w_pend_after && (w_wc_after != '0))) begin
      r_checksum <= 16'h0000;
    end else if ((r_state == REQ) && sd_ack) begin
      r_checksum <= r_checksum + w_rd_data;
    end
  end

  assign checksum = r_checksum;
`endif

  // Read data is only meaningful while a request is up.
  assign sd_data_word    = (r_state == REQ) ? w_rd_data : 16'h0000;
  assign sd_address_word = r_drain_ptr;
  assign sd_req          = r_sd_req;
  assign byte_ready      = r_byte_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign word_count      = r_word_count;

endmodule

// File: tb/tb_result_word_writer.sv
// Self-checking bench for result_word_writer: directed and randomized byte
// streams compared against a queue-based model of the packed word stream.
module tb_result_word_writer;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          CLOCK_50 = 1'b0;
  logic          RESET;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          flush;
  logic          sd_req;
  logic [AW-1:0] sd_address_word;
  logic [15:0]   sd_data_word;
  logic          sd_ack;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;
`ifdef RESULT_WRITER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] bq[$];

  result_word_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLOCK_50        (CLOCK_50),
    .RESET           (RESET),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .flush           (flush),
    .sd_req          (sd_req),
    .sd_address_word (sd_address_word),
    .sd_data_word    (sd_data_word),
    .sd_ack          (sd_ack),
    .busy            (busy),
    .done            (done),
`ifdef RESULT_WRITER_CHECKSUM_EN
    .checksum        (checksum),
`endif
    .word_count      (word_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit rdy;
    rdy = (bq.size() / 2) < DEPTH;
    byte_valid = 1'b1;
    byte_data  = b;
    check("byte_ready", {31'd0, byte_ready}, {31'd0, rdy});
    if (rdy) bq.push_back(b);
    tick();
    byte_valid = 1'b0;
    check("word_count", {22'd0, word_count}, bq.size() / 2);
  endtask

  task automatic flush_drain(input int ack_delay, input bit with_byte, input logic [7:0] b);
    logic [15:0] words[$];
    logic [15:0] sum;
    bit pad;
    int lat;
    flush = 1'b1;
    if (with_byte) begin
      byte_valid = 1'b1;
      byte_data  = b;
      if ((bq.size() / 2) < DEPTH) bq.push_back(b);
    end
    pad = (bq.size() % 2) == 1;
    tick();
    flush = 1'b0;
    byte_valid = 1'b0;
    for (int i = 0; i < bq.size(); i += 2)
      words.push_back({(i + 1 < bq.size()) ? bq[i+1] : 8'h00, bq[i]});
    if (words.size() == 0) begin
      check("empty_done", {31'd0, done}, 32'd1);
      check("empty_no_req", {31'd0, sd_req}, 32'd0);
      tick();
      check("empty_done_drop", {31'd0, done}, 32'd0);
      check("empty_ready", {31'd0, byte_ready}, 32'd1);
      return;
    end
    check("busy_after_flush", {31'd0, busy}, 32'd1);
    check("no_early_done", {31'd0, done}, 32'd0);
    sum = 16'h0000;
    for (int i = 0; i < words.size(); i++) begin
      lat = 0;
      while (!sd_req && lat < 12) begin
        tick();
        lat++;
      end
      check("req_seen", {31'd0, sd_req}, 32'd1);
      if (i == 0) check("first_req_latency", lat, pad ? 32'd2 : 32'd1);
      else        check("word_gap", lat, 32'd1);
      check("addr", {23'd0, sd_address_word}, i);
      check("data", {16'd0, sd_data_word}, {16'd0, words[i]});
      for (int k = 0; k < ack_delay; k++) begin
        tick();
        check("stall_stable", {6'd0, sd_req, sd_address_word, sd_data_word},
              {6'd0, 1'b1, AW'(i), words[i]});
      end
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      sum = sum + words[i];
      check("req_drop_after_ack", {31'd0, sd_req}, 32'd0);
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
`ifdef RESULT_WRITER_CHECKSUM_EN
    check("checksum", {16'd0, checksum}, {16'd0, sum});
`endif
    tick();
    check("done_single", {31'd0, done}, 32'd0);
    check("count_cleared", {22'd0, word_count}, 32'd0);
    check("ready_back", {31'd0, byte_ready}, 32'd1);
    check("busy_clear", {31'd0, busy}, 32'd0);
    bq.delete();
  endtask

  initial begin
    int lat;
    RESET = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; flush = 1'b0; sd_ack = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    tick();
    check("rst_ready", {31'd0, byte_ready}, 32'd1);
    check("rst_req", {31'd0, sd_req}, 32'd0);
    check("rst_addr", {23'd0, sd_address_word}, 32'd0);
    check("rst_data", {16'd0, sd_data_word}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", {22'd0, word_count}, 32'd0);

    // Four bytes, two words, ack immediate.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    flush_drain(0, 1'b0, 8'h00);

    // Single byte needs padding.
    push_byte(8'hAB);
    flush_drain(0, 1'b0, 8'h00);

    // Empty flush, then flush with a byte in the same cycle.
    flush_drain(0, 1'b0, 8'h00);
    flush_drain(0, 1'b1, 8'h7F);

    // Stalled acknowledges.
    for (int i = 0; i < 6; i++) push_byte(8'(i * 37 + 5));
    flush_drain(5, 1'b0, 8'h00);

    // Randomized rounds with gaps and random ack latency.
    for (int r = 0; r < 8; r++) begin
      int nb;
      nb = $urandom_range(0, 20);
      for (int i = 0; i < nb; i++) begin
        push_byte(8'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
      flush_drain($urandom_range(0, 4), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Fill to capacity; the extra byte must be refused.
    for (int i = 0; i < 2 * DEPTH; i++) push_byte(8'(i));
    check("full_count", {22'd0, word_count}, DEPTH);
    push_byte(8'hEE);
    check("last_word_model", {16'd0, bq[2*DEPTH-1], bq[2*DEPTH-2]}, 32'h0000FFFE);
    flush_drain(0, 1'b0, 8'h00);

    // Reset during second word of a four-word drain.
    for (int i = 0; i < 8; i++) push_byte(8'($urandom));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    lat = 0;
    while (!sd_req && lat < 12) begin tick(); lat++; end
    check("rst_drain_req0", {31'd0, sd_req}, 32'd1);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    lat = 0;
    while (!sd_req && lat < 12) begin tick(); lat++; end
    check("rst_drain_req1", {31'd0, sd_req}, 32'd1);
    check("rst_drain_addr1", {23'd0, sd_address_word}, 32'd1);
    RESET = 1'b1;
    #1;
    check("async_req_drop", {31'd0, sd_req}, 32'd0);
    check("async_ready", {31'd0, byte_ready}, 32'd1);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_count", {22'd0, word_count}, 32'd0);
    check("async_addr", {23'd0, sd_address_word}, 32'd0);
    check("async_data", {16'd0, sd_data_word}, 32'd0);
    bq.delete();
    tick();
    RESET = 1'b0;
    tick();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    flush_drain(1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
